// File: rtl/pixel_tap_pkg.sv
// Shared types, widths and the hysteresis threshold helper for the analyzer channels.
package pixel_tap_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FRAME = 2'd1,
    ACTIVE     = 2'd2
  } tap_state_t;

  localparam int PIXEL_WIDTH       = 8;
  localparam int FRAME_COUNT_WIDTH = 16;

  // At or above high forces 1, below low forces 0, in between keeps the current level.
  function automatic logic threshold_level(
    input logic [PIXEL_WIDTH-1:0] value,
    input logic                   current,
    input logic [PIXEL_WIDTH-1:0] high,
    input logic [PIXEL_WIDTH-1:0] low
  );
    if (value >= high) return 1'b1;
    if (value < low)   return 1'b0;
    return current;
  endfunction

endpackage

// File: rtl/pixel_tap_watchdog.sv
// Stalled-stream watchdog: counts clocks since the last accepted frame_start and
// raises stalled once the count reaches FRAME_TIMEOUT; the count then holds.
module pixel_tap_watchdog #(
  parameter int unsigned FRAME_TIMEOUT = 4000000
) (
  input  logic clock,
  input  logic reset,
  input  logic run,
  input  logic restart,
  output logic stalled
);

  localparam logic [31:0] LIMIT = 32'(FRAME_TIMEOUT);

  logic [31:0] count;

  always_ff @(posedge clock) begin
    if (reset || !run || restart) begin
      count <= '0;
    end else if (count != LIMIT) begin
      count <= count + 32'd1;
    end
  end

  assign stalled = (count == LIMIT);

endmodule

// File: rtl/pixel_tap_sampler.sv
// Frame-aligned pixel tap with hysteresis threshold, frame counter and watchdog.
// Define PIXEL_TAP_AVERAGE_EN to average four consecutive valid pixels at the tap.
module pixel_tap_sampler
  import pixel_tap_pkg::*;
#(
  parameter int unsigned PIXEL_INDEX    = 63,
  parameter int unsigned LINE_INDEX     = 0,
  parameter int unsigned THRESHOLD_HIGH = 192,
  parameter int unsigned THRESHOLD_LOW  = 160,
  parameter int unsigned COUNTER_WIDTH  = 12,
  parameter int unsigned FRAME_TIMEOUT  = 4000000
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         enable,
  input  logic [PIXEL_WIDTH-1:0]       data,
  input  logic                         data_valid,
  input  logic                         line_start,
  input  logic                         frame_start,
  output logic                         sample_data,
  output logic                         sample_strobe,
  output logic [PIXEL_WIDTH-1:0]       pixel_value,
  output logic [FRAME_COUNT_WIDTH-1:0] frame_count,
  output logic                         stalled
);

  localparam logic [COUNTER_WIDTH-1:0] TGT_LINE = COUNTER_WIDTH'(LINE_INDEX);
  localparam logic [COUNTER_WIDTH-1:0] TGT_COL  = COUNTER_WIDTH'(PIXEL_INDEX);
  localparam logic [PIXEL_WIDTH-1:0]   TH_HIGH  = PIXEL_WIDTH'(THRESHOLD_HIGH);
  localparam logic [PIXEL_WIDTH-1:0]   TH_LOW   = PIXEL_WIDTH'(THRESHOLD_LOW);

  function automatic logic [COUNTER_WIDTH-1:0] sat_inc(input logic [COUNTER_WIDTH-1:0] v);
    return (&v) ? v : v + COUNTER_WIDTH'(1);
  endfunction

  tap_state_t               state, state_next;
  logic [COUNTER_WIDTH-1:0] line_q, col_q, line_eff, col_eff;
  logic                     frame_go, in_frame, tap_hit, fire, level;
  logic [PIXEL_WIDTH-1:0]   cap_value;

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:       if (enable) state_next = WAIT_FRAME;
      WAIT_FRAME: if (!enable) state_next = IDLE;
                  else if (frame_start) state_next = ACTIVE;
      ACTIVE:     if (!enable) state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  // A pixel arriving alongside a start pulse already belongs to the new line.
  always_comb begin
    frame_go = enable && frame_start && (state != IDLE);
    in_frame = enable && ((state == ACTIVE) || ((state == WAIT_FRAME) && frame_start));
    line_eff = frame_start ? '0 : (line_start ? sat_inc(line_q) : line_q);
    col_eff  = (frame_start || line_start) ? '0 : col_q;
    tap_hit  = in_frame && data_valid && (line_eff == TGT_LINE);
  end

`ifdef PIXEL_TAP_AVERAGE_EN
  logic [9:0] sum_q, sum_with;
  logic [1:0] taken_q, taken_base;
  logic       slot_ok;

  // Any start pulse before the fourth pixel discards the partial sum.
  always_comb begin
    taken_base = (frame_start || line_start) ? 2'd0 : taken_q;
    slot_ok    = tap_hit && (col_eff == TGT_COL + COUNTER_WIDTH'(taken_base));
    sum_with   = ((taken_base == 2'd0) ? 10'd0 : sum_q) + {2'b00, data};
    fire       = slot_ok && (taken_base == 2'd3);
    cap_value  = sum_with[9:2];
  end

  always_ff @(posedge clock) begin
    if (reset || !in_frame) begin
      taken_q <= 2'd0;
      sum_q   <= '0;
    end else if (slot_ok) begin
      taken_q <= taken_base + 2'd1;
      sum_q   <= sum_with;
    end else begin
      taken_q <= taken_base;
    end
  end
`else
  always_comb begin
    fire      = tap_hit && (col_eff == TGT_COL);
    cap_value = data;
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      line_q        <= '0;
      col_q         <= '0;
      sample_strobe <= 1'b0;
      pixel_value   <= '0;
      level         <= 1'b0;
      frame_count   <= '0;
    end else begin
      state         <= state_next;
      line_q        <= line_eff;
      col_q         <= data_valid ? sat_inc(col_eff) : col_eff;
      sample_strobe <= fire;
      if (fire) pixel_value <= cap_value;
      if (!enable || stalled) level <= 1'b0;
      else if (fire) level <= threshold_level(cap_value, level, TH_HIGH, TH_LOW);
      if ((state == IDLE) && enable) frame_count <= '0;
      else if (frame_go) frame_count <= frame_count + 1'b1;
    end
  end

  assign sample_data = level && !stalled;

  pixel_tap_watchdog #(
    .FRAME_TIMEOUT(FRAME_TIMEOUT)
  ) u_watchdog (
    .clock  (clock),
    .reset  (reset),
    .run    (enable && (state != IDLE)),
    .restart(frame_go),
    .stalled(stalled)
  );

endmodule

// File: tb/tb_pixel_tap_sampler.sv
// Randomized frame stream checked against a frame-level reference model of the tap.
module tb_pixel_tap_sampler;

  localparam int PIX_IDX = 63;
  localparam int LINE_IDX = 0;
  localparam int TIMEOUT = 1000;
`ifdef PIXEL_TAP_AVERAGE_EN
  localparam int NTAP = 4;
`else
  localparam int NTAP = 1;
`endif
  localparam int EW = 41;

  logic        clock = 1'b0;
  logic        reset, enable, data_valid, line_start, frame_start;
  logic [7:0]  data;
  logic        sample_data, sample_strobe, stalled;
  logic [7:0]  pixel_value;
  logic [15:0] frame_count;

  int          cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  logic [EW-1:0] exp_q[$];
  logic [7:0]  tgt_vals[4];
  logic        model_level = 1'b0;
  logic [7:0]  model_pv = 8'd0;
  int          model_fc = 0;

  pixel_tap_sampler #(
    .FRAME_TIMEOUT(TIMEOUT)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .data         (data),
    .data_valid   (data_valid),
    .line_start   (line_start),
    .frame_start  (frame_start),
    .sample_data  (sample_data),
    .sample_strobe(sample_strobe),
    .pixel_value  (pixel_value),
    .frame_count  (frame_count),
    .stalled      (stalled)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic px(input logic fs, input logic ls, input logic dv, input logic [7:0] d);
    frame_start = fs;
    line_start  = ls;
    data_valid  = dv;
    data        = d;
    step();
  endtask

  task automatic set_tgt(input logic [7:0] v);
    tgt_vals = '{v, v, v, v};
  endtask

  // The tapped value lands on the outputs one clock after the last tap pixel.
  task automatic expect_capture();
    logic [7:0] v;
    if (NTAP == 1) v = tgt_vals[0];
    else v = 8'((10'(tgt_vals[0]) + 10'(tgt_vals[1]) + 10'(tgt_vals[2]) + 10'(tgt_vals[3])) / 4);
    if (v >= 8'd192) model_level = 1'b1;
    else if (v < 8'd160) model_level = 1'b0;
    model_pv = v;
    exp_q.push_back({32'(cyc + 1), model_level, v});
  endtask

  task automatic drive_frame(input int nlines, input int npix);
    int col;
    logic dv;
    logic [7:0] d;
    model_fc++;
    for (int l = 0; l < nlines; l++) begin
      col = 0;
      for (int t = 0; col < npix; t++) begin
        dv = (t == 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 3) != 0);
        d  = 8'($urandom);
        if (dv && l == LINE_IDX && col >= PIX_IDX && col < PIX_IDX + NTAP) begin
          d = tgt_vals[col - PIX_IDX];
          if (col == PIX_IDX + NTAP - 1) expect_capture();
        end
        px(l == 0 && t == 0, l > 0 && t == 0, dv, d);
        if (dv) col++;
      end
      repeat ($urandom_range(1, 3)) px(1'b0, 1'b0, 1'b0, 8'd0);
    end
    check("frame_count", 32'(frame_count), 32'(model_fc));
  endtask

  // Scoreboard: every cycle the strobe must match the queue head.
  always @(negedge clock) begin
    logic [EW-1:0] e;
    logic exp_strobe;
    exp_strobe = (exp_q.size() > 0) && (exp_q[0][40:9] == 32'(cyc));
    check("sample_strobe", 32'(sample_strobe), 32'(exp_strobe));
    if (exp_strobe) begin
      e = exp_q.pop_front();
      check("pixel_value", 32'(pixel_value), 32'(e[7:0]));
      check("sample_data", 32'(sample_data), 32'(e[8]));
    end
  end

  initial begin
    reset = 1'b1;
    enable = 1'b0;
    frame_start = 1'b0;
    line_start = 1'b0;
    data_valid = 1'b0;
    data = 8'd0;
    repeat (3) step();
    check("reset_sample_data", 32'(sample_data), 0);
    check("reset_strobe", 32'(sample_strobe), 0);
    check("reset_pixel_value", 32'(pixel_value), 0);
    check("reset_frame_count", 32'(frame_count), 0);
    check("reset_stalled", 32'(stalled), 0);
    reset = 1'b0;
    enable = 1'b1;
    repeat (2) step();

    set_tgt(8'd200);
    repeat (3) drive_frame(2, 70);

    foreach (tgt_vals[i]) begin
      logic [7:0] hv[4];
      hv = '{8'd200, 8'd170, 8'd150, 8'd170};
      set_tgt(hv[i]);
      drive_frame(1, 70);
      check("hyst_level", 32'(sample_data), 32'(model_level));
    end

    tgt_vals = '{8'd100, 8'd200, 8'd250, 8'd250};
    drive_frame(1, 70);

    set_tgt(8'd200);
    drive_frame(1, 70);
    drive_frame(1, 40);
    check("short_hold_level", 32'(sample_data), 32'(model_level));
    check("short_hold_pixel", 32'(pixel_value), 32'(model_pv));

    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < 4; i++) tgt_vals[i] = 8'($urandom_range(140, 220));
      drive_frame($urandom_range(1, 3), $urandom_range(40, 80));
    end

    set_tgt(8'd200);
    drive_frame(1, 70);
    px(1'b1, 1'b0, 1'b0, 8'd0);
    model_fc++;
    repeat (TIMEOUT - 1) px(1'b0, 1'b0, 1'b0, 8'd0);
    check("stall_before_limit", 32'(stalled), 0);
    px(1'b0, 1'b0, 1'b0, 8'd0);
    check("stall_at_limit", 32'(stalled), 1);
    check("stall_forces_low", 32'(sample_data), 0);
    model_level = 1'b0;
    px(1'b1, 1'b0, 1'b0, 8'd0);
    model_fc++;
    check("stall_cleared", 32'(stalled), 0);
    check("stall_frame_count", 32'(frame_count), 32'(model_fc));
    repeat (3) px(1'b0, 1'b0, 1'b0, 8'd0);

    drive_frame(1, 70);
    px(1'b1, 1'b0, 1'b1, 8'($urandom));
    model_fc++;
    for (int c = 1; c < 30; c++) px(1'b0, 1'b0, 1'b1, 8'($urandom));
    enable = 1'b0;
    px(1'b0, 1'b0, 1'b1, 8'($urandom));
    model_level = 1'b0;
    check("disable_sample_data", 32'(sample_data), 0);
    check("disable_stalled", 32'(stalled), 0);
    check("disable_frame_count", 32'(frame_count), 32'(model_fc));
    check("disable_pixel_value", 32'(pixel_value), 32'(model_pv));
    for (int c = 31; c < 40; c++) px(1'b0, 1'b0, 1'b1, 8'($urandom));
    enable = 1'b1;
    for (int c = 40; c < 70; c++) px(1'b0, 1'b0, 1'b1, (c == PIX_IDX) ? 8'd200 : 8'($urandom));
    model_fc = 0;
    check("reenable_frame_count", 32'(frame_count), 0);
    check("reenable_no_capture", 32'(sample_data), 0);
    repeat (2) px(1'b0, 1'b0, 1'b0, 8'd0);
    drive_frame(1, 70);

    repeat (3) step();
    check("exp_q_drained", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
